// File: rtl/apb_pkg.sv
// ----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB command master and its helpers.
//   - apb_state_e : transfer state encoding (IDLE, SETUP, ACCESS, RESP)
//   - APB_ADDR_W / APB_DATA_W : default bus widths
//   - REGION_MSB / REGION_LSB : slave region field used by the address decoder
// ----------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // The downstream decoder selects a slave from PADDR[31:28].
    localparam int REGION_MSB = 31;
    localparam int REGION_LSB = 28;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Slave region of a full-width APB address.
    function automatic logic [REGION_MSB-REGION_LSB:0] apb_region(
        input logic [APB_ADDR_W-1:0] addr
    );
        return addr[REGION_MSB:REGION_LSB];
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ----------------------------------------------------------------------------
// apb_wait_timer
// Counts ACCESS cycles in which the slave holds PREADY low and flags when the
// count reaches TIMEOUT-1, i.e. the current wait cycle is the last allowed one.
// TIMEOUT = 0 disables the timer (expired tied low).
// Ports:
//   PCLK     in  clock
//   PRESETn  in  asynchronous active-low reset
//   clear    in  force the count to zero
//   count_en in  increment the count this cycle
//   expired  out count == TIMEOUT-1 (combinational from the count)
// ----------------------------------------------------------------------------
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int TO_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt_reg;
    logic [TO_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (count_en) begin
            cnt_next = cnt_reg + TO_W'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            assign expired = (cnt_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_cmd_master.sv
// ----------------------------------------------------------------------------
// apb_cmd_master
// Turns a valid/ready command stream into APB SETUP/ACCESS transfers and
// returns one registered response per command. One transfer in flight.
// Ports:
//   PCLK, PRESETn            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake (cmd_ready high only in IDLE)
//   cmd_write/addr/wdata     command payload, captured on accept
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata/err/timeout    response payload
//   PSEL..PWDATA             APB requester outputs (all registered)
//   PRDATA/PREADY/PSLVERR    muxed APB slave returns
// ----------------------------------------------------------------------------
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_e        state_reg,       state_next;
    logic              psel_reg,        psel_next;
    logic              penable_reg,     penable_next;
    logic              pwrite_reg,      pwrite_next;
    logic [ADDR_W-1:0] paddr_reg,       paddr_next;
    logic [DATA_W-1:0] pwdata_reg,      pwdata_next;
    logic              rsp_valid_reg,   rsp_valid_next;
    logic [DATA_W-1:0] rsp_rdata_reg,   rsp_rdata_next;
    logic              rsp_err_reg,     rsp_err_next;
    logic              rsp_timeout_reg, rsp_timeout_next;

    logic timer_clear;
    logic timer_count;
    logic timer_expired;

    // The wait count is only meaningful inside ACCESS; holding it at zero
    // everywhere else guarantees every transfer starts from a clean count.
    assign timer_clear = (state_reg != ST_ACCESS);
    assign timer_count = (state_reg == ST_ACCESS) && !PREADY;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .clear    (timer_clear),
        .count_en (timer_count),
        .expired  (timer_expired)
    );

    always_comb begin
        state_next       = state_reg;
        psel_next        = psel_reg;
        penable_next     = penable_reg;
        pwrite_next      = pwrite_reg;
        paddr_next       = paddr_reg;
        pwdata_next      = pwdata_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_err_next     = rsp_err_reg;
        rsp_timeout_next = rsp_timeout_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    pwrite_next  = cmd_write;
                    paddr_next   = cmd_addr;
                    pwdata_next  = cmd_wdata;
                    psel_next    = 1'b1;
                    penable_next = 1'b0;
                    state_next   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_next = 1'b1;
                state_next   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY is checked first so a slave answering in the final
                // allowed cycle still completes normally.
                if (PREADY) begin
                    rsp_rdata_next   = (pwrite_reg || PSLVERR) ? '0 : PRDATA;
                    rsp_err_next     = PSLVERR;
                    rsp_timeout_next = 1'b0;
                    rsp_valid_next   = 1'b1;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    state_next       = ST_RESP;
                end else if (timer_expired) begin
                    rsp_rdata_next   = '0;
                    rsp_err_next     = 1'b1;
                    rsp_timeout_next = 1'b1;
                    rsp_valid_next   = 1'b1;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    state_next       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                psel_next    = 1'b0;
                penable_next = 1'b0;
                state_next   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg       <= ST_IDLE;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            pwrite_reg      <= 1'b0;
            paddr_reg       <= '0;
            pwdata_reg      <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            psel_reg        <= psel_next;
            penable_reg     <= penable_next;
            pwrite_reg      <= pwrite_next;
            paddr_reg       <= paddr_next;
            pwdata_reg      <= pwdata_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_err_reg     <= rsp_err_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    assign cmd_ready   = (state_reg == ST_IDLE);
    assign PSEL        = psel_reg;
    assign PENABLE     = penable_reg;
    assign PWRITE      = pwrite_reg;
    assign PADDR       = paddr_reg;
    assign PWDATA      = pwdata_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_apb_cmd_master.sv
// ----------------------------------------------------------------------------
// tb_apb_cmd_master
// Directed vector table, randomized transfers against a behavioural model of
// a programmable-wait APB slave, plus hand sequences for back-pressure with a
// pending command and reset during ACCESS.
// ----------------------------------------------------------------------------
module tb_apb_cmd_master;

    localparam int TO = 16;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    // Slave model: PREADY rises after slv_wait completed ACCESS cycles.
    int          acc;
    int          slv_wait = 0;
    logic        slv_err = 1'b0;
    logic [31:0] slv_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)            acc <= 0;
        else if (PSEL && PENABLE) acc <= acc + 1;
        else                     acc <= 0;
    end

    assign PREADY  = PSEL && PENABLE && (acc == slv_wait);
    assign PSLVERR = PREADY && slv_err;
    assign PRDATA  = slv_rdata;

    apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wt;      // slave wait cycles before PREADY
        logic        serr;
        logic [31:0] prd;
        int          hold;    // cycles rsp_ready held low
        logic        e_err;
        logic        e_to;
        logic [31:0] e_rdata;
        int          e_lat;   // cycles from accept edge to rsp_valid
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: a slave waiting wt cycles answers in ACCESS cycle wt+1
    // unless that exceeds the TO-cycle budget, in which case it times out.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int   acc_n;
        r.e_to    = (v.wt >= TO);
        acc_n     = r.e_to ? TO : v.wt + 1;
        r.e_err   = r.e_to | v.serr;
        r.e_rdata = (r.e_to || v.wr || v.serr) ? 32'h0 : v.prd;
        r.e_lat   = 2 + acc_n;
        return r;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int          lat = 0;
        int          acc_seen = 0;
        int          bad = 0;
        bit          got = 0;
        logic [33:0] snap;
        @(negedge PCLK);
        cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_valid = 1'b1;
        slv_wait = v.wt; slv_err = v.serr; slv_rdata = v.prd;
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        for (int c = 1; c <= 100 && !got; c++) begin
            @(negedge PCLK);
            if (c == 1) begin
                chk("setup_psel_penable", {PSEL, PENABLE}, 2'b10);
                chk("setup_cmd_ready", cmd_ready, 1'b0);
            end
            if (PSEL && PENABLE) begin
                acc_seen++;
                if (PADDR !== v.addr || PWRITE !== v.wr || PWDATA !== v.wdata) bad++;
            end
            if (rsp_valid) begin
                got = 1;
                lat = c;
            end
        end
        if (!got) chk("rsp_wait_bound", 0, 1);
        chk("rsp_latency", lat, v.e_lat);
        chk("access_cycles", acc_seen, v.e_lat - 2);
        chk("access_stable", bad, 0);
        chk("resp_psel", {PSEL, PENABLE}, 2'b00);
        chk("rsp_rdata", rsp_rdata, v.e_rdata);
        chk("rsp_err", rsp_err, v.e_err);
        chk("rsp_timeout", rsp_timeout, v.e_to);
        snap = {rsp_rdata, rsp_err, rsp_timeout};
        bad = 0;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge PCLK);
            if (!rsp_valid || cmd_ready || PSEL || {rsp_rdata, rsp_err, rsp_timeout} !== snap) bad++;
        end
        chk("rsp_hold_stable", bad, 0);
        rsp_ready = 1'b1;
        @(posedge PCLK);
        #1 rsp_ready = 1'b0;
        @(negedge PCLK);
        chk("post_rsp_valid", rsp_valid, 1'b0);
        chk("post_cmd_ready", cmd_ready, 1'b1);
        chk("post_paddr_kept", PADDR, v.addr);
        $display("TXN %0d wr=%0d addr=%08h wait=%0d lat=%0d rdata=%08h err=%0d to=%0d",
                 idx, v.wr, v.addr, v.wt, lat, rsp_rdata, rsp_err, rsp_timeout);
    endtask

    vec_t table_v[6];
    vec_t rv;

    initial begin
        // Reset state
        #2;
        chk("reset_cmd_ready", cmd_ready, 1'b1);
        chk("reset_outputs", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}, 6'b0);
        chk("reset_buses", {PADDR, PWDATA, rsp_rdata}, 96'h0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;

        //            wr    addr          wdata         wt    serr  prd           hold err   to    rdata         lat
        table_v[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1,    1'b0, 32'h0,        0, 1'b0, 1'b0, 32'h0,        4};
        table_v[1] = '{1'b0, 32'h0000_0010, 32'h0,         0,    1'b0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 3};
        table_v[2] = '{1'b0, 32'h0000_0010, 32'h0,         0,    1'b1, 32'h1234_5678, 1, 1'b1, 1'b0, 32'h0,        3};
        table_v[3] = '{1'b0, 32'h4000_0000, 32'h0,         1000, 1'b0, 32'h5555_AAAA, 0, 1'b1, 1'b1, 32'h0,        18};
        table_v[4] = '{1'b0, 32'h2000_0004, 32'h0,         15,   1'b0, 32'hA5A5_0001, 0, 1'b0, 1'b0, 32'hA5A5_0001, 18};
        table_v[5] = '{1'b1, 32'h3000_0008, 32'h0BAD_F00D, 0,    1'b1, 32'hFFFF_FFFF, 2, 1'b1, 1'b0, 32'h0,        3};
        for (int i = 0; i < 6; i++) run_vec(i, table_v[i]);

        // Randomized transfers
        for (int i = 0; i < 30; i++) begin
            int sel;
            rv.wr    = 1'($urandom_range(0, 1));
            rv.addr  = $urandom;
            rv.wdata = $urandom;
            rv.prd   = $urandom;
            rv.serr  = ($urandom_range(0, 3) == 0);
            rv.hold  = $urandom_range(0, 3);
            sel = $urandom_range(0, 9);
            case (sel)
                6:       rv.wt = 15;
                7:       rv.wt = 14;
                8:       rv.wt = 16;
                9:       rv.wt = $urandom_range(17, 30);
                default: rv.wt = $urandom_range(0, 3);
            endcase
            run_vec(100 + i, model(rv));
        end

        // Back-pressure with a second command pending
        begin
            int bad = 0;
            int lat = 0;
            logic [33:0] snap;
            @(negedge PCLK);
            slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h7777_0000;
            cmd_write = 1'b0; cmd_addr = 32'h1000_0000; cmd_wdata = '0; cmd_valid = 1'b1;
            @(posedge PCLK);
            #1;
            cmd_write = 1'b0; cmd_addr = 32'h1000_0004; cmd_wdata = 32'h0;
            for (int c = 1; c <= 50 && lat == 0; c++) begin
                @(negedge PCLK);
                if (rsp_valid) lat = c;
            end
            chk("bp_first_latency", lat, 3);
            chk("bp_first_rdata", rsp_rdata, 32'h7777_0000);
            slv_wait = 2; slv_rdata = 32'hCAFE_0001;
            snap = {rsp_rdata, rsp_err, rsp_timeout};
            for (int h = 0; h < 5; h++) begin
                @(negedge PCLK);
                if (!rsp_valid || cmd_ready || PSEL || {rsp_rdata, rsp_err, rsp_timeout} !== snap) bad++;
            end
            chk("bp_hold_stable", bad, 0);
            rsp_ready = 1'b1;
            @(posedge PCLK);
            #1 rsp_ready = 1'b0;
            @(negedge PCLK);
            chk("bp_idle_ready", {cmd_ready, PSEL}, 2'b10);
            @(posedge PCLK);
            #1 cmd_valid = 1'b0;
            @(negedge PCLK);
            chk("bp_second_setup", {PSEL, PENABLE}, 2'b10);
            chk("bp_second_paddr", PADDR, 32'h1000_0004);
            lat = 0;
            for (int c = 2; c <= 50 && lat == 0; c++) begin
                @(negedge PCLK);
                if (rsp_valid) lat = c;
            end
            chk("bp_second_latency", lat, 5);
            chk("bp_second_rdata", rsp_rdata, 32'hCAFE_0001);
            rsp_ready = 1'b1;
            @(posedge PCLK);
            #1 rsp_ready = 1'b0;
            $display("TXN bp second cmd lat=%0d rdata=%08h", lat, rsp_rdata);
        end

        // Reset during ACCESS
        begin
            int bad = 0;
            @(negedge PCLK);
            slv_wait = 1000; slv_err = 1'b0;
            cmd_write = 1'b0; cmd_addr = 32'h4000_0000; cmd_valid = 1'b1;
            @(posedge PCLK);
            #1 cmd_valid = 1'b0;
            repeat (4) @(negedge PCLK);
            chk("rst_in_access", {PSEL, PENABLE}, 2'b11);
            #2 PRESETn = 1'b0;
            #1;
            chk("rst_async_apb", {PSEL, PENABLE, rsp_valid}, 3'b000);
            chk("rst_async_ready", cmd_ready, 1'b1);
            @(negedge PCLK);
            PRESETn = 1'b1;
            for (int c = 0; c < 25; c++) begin
                @(negedge PCLK);
                if (rsp_valid || PSEL || !cmd_ready) bad++;
            end
            chk("rst_no_response", bad, 0);
            $display("TXN reset mid-access bad_cycles=%0d", bad);
        end

        // Normal transfer after reset
        rv = '{1'b0, 32'h0000_0020, 32'h0, 0, 1'b0, 32'h0102_0304, 0, 1'b0, 1'b0, 32'h0, 0};
        run_vec(200, model(rv));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
